// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch direction predictor: counter encodings,
// the per-stage prediction metadata record, and the saturating update rule.
package branch_resolve_unit_pkg;

  localparam logic [1:0] CTR_SNT   = 2'd0;
  localparam logic [1:0] CTR_WNT   = 2'd1;
  localparam logic [1:0] CTR_WT    = 2'd2;
  localparam logic [1:0] CTR_ST    = 2'd3;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        predTaken;
    logic [31:0] predTarget;
  } bp_meta_t;

  function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != CTR_ST) res = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bimodal_bht.sv
// Bimodal history table: 2-bit saturating counters with one combinational
// read port and one synchronous update port. Reads never see a same-cycle write.
module bimodal_bht
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_LEN = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] rdIdx_i,
  output logic [1:0]          rdCtr_o,
  input  logic                wrEn_i,
  input  logic [ADDR_LEN-1:0] wrIdx_i,
  input  logic                wrTaken_i
);

  localparam int DEPTH = 1 << ADDR_LEN;

  logic [1:0] ctr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RESET;
    end else if (wrEn_i) begin
      ctr_q[wrIdx_i] <= satUpdate(ctr_q[wrIdx_i], wrTaken_i);
    end
  end

  assign rdCtr_o = ctr_q[rdIdx_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// Fetch-side direction prediction on top of the BTB, plus EX-side resolution:
// mispredict/redirect, BHT training, BTB write requests and branch statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_ADDR_LEN = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  input  logic        stall,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic        btb_wr_req,
  output logic [31:0] btb_wr_pc,
  output logic [31:0] btb_wr_target,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  bp_meta_t ifid_q, ifid_d;
  bp_meta_t idex_q, idex_d;

  logic        btbWrReq_q;
  logic [31:0] btbWrPc_q;
  logic [31:0] btbWrTarget_q;
  logic [31:0] branchCnt_q;
  logic [31:0] mispredictCnt_q;

  logic [1:0]  ifCtr;
  logic        exValid;
  logic        resolveBranch;
  logic        targetMismatch;
  logic        btbWrNeed;

  bimodal_bht #(.ADDR_LEN(BHT_ADDR_LEN)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rdIdx_i  (if_pc[BHT_ADDR_LEN+1:2]),
    .rdCtr_o  (ifCtr),
    .wrEn_i   (resolveBranch),
    .wrIdx_i  (idex_q.pc[BHT_ADDR_LEN+1:2]),
    .wrTaken_i(ex_taken)
  );

  assign pred_taken = btb_hit & ifCtr[1];
  assign pred_pc    = pred_taken ? btb_target : if_pc + 32'd4;

  // Non-branches that were predicted taken come from a stale BTB alias and
  // only need a fall-through redirect; they never train the BHT or BTB.
  always_comb begin
    exValid        = idex_q.valid & ~stall;
    resolveBranch  = exValid & ex_is_branch;
    targetMismatch = ex_target != idex_q.predTarget;
    mispredict     = 1'b0;
    btbWrNeed      = 1'b0;
    redirect_pc    = idex_q.pc + 32'd4;
    if (resolveBranch) begin
      mispredict = (ex_taken != idex_q.predTaken) |
                   (ex_taken & idex_q.predTaken & targetMismatch);
      btbWrNeed  = ex_taken & (~idex_q.predTaken | targetMismatch);
      if (ex_taken) redirect_pc = ex_target;
    end else if (exValid && idex_q.predTaken) begin
      mispredict = 1'b1;
    end
  end

  always_comb begin
    ifid_d = '{valid: 1'b1, pc: if_pc, predTaken: pred_taken, predTarget: btb_target};
    idex_d = ifid_q;
    if (mispredict) begin
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q          <= '0;
      idex_q          <= '0;
      btbWrReq_q      <= 1'b0;
      btbWrPc_q       <= '0;
      btbWrTarget_q   <= '0;
      branchCnt_q     <= '0;
      mispredictCnt_q <= '0;
    end else begin
      if (!stall) begin
        ifid_q <= ifid_d;
        idex_q <= idex_d;
      end
      btbWrReq_q <= btbWrNeed;
      if (btbWrNeed) begin
        btbWrPc_q     <= idex_q.pc;
        btbWrTarget_q <= ex_target;
      end
      if (resolveBranch) begin
        branchCnt_q     <= branchCnt_q + 32'd1;
        mispredictCnt_q <= mispredictCnt_q + {31'd0, mispredict};
      end
    end
  end

  assign btb_wr_req     = btbWrReq_q;
  assign btb_wr_pc      = btbWrPc_q;
  assign btb_wr_target  = btbWrTarget_q;
  assign branch_cnt     = branchCnt_q;
  assign mispredict_cnt = mispredictCnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized bench for branch_resolve_unit, checked every cycle
// against a queue-based behavioural model of the prediction pipeline.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        stall;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        btb_wr_req;
  logic [31:0] btb_wr_pc;
  logic [31:0] btb_wr_target;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .btb_hit       (btb_hit),
    .btb_target    (btb_target),
    .pred_taken    (pred_taken),
    .pred_pc       (pred_pc),
    .stall         (stall),
    .ex_is_branch  (ex_is_branch),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .btb_wr_req    (btb_wr_req),
    .btb_wr_pc     (btb_wr_pc),
    .btb_wr_target (btb_wr_target),
    .branch_cnt    (branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  // Model: in-flight fetches as a queue (index 0 = IF/ID, index 1 = ID/EX).
  typedef struct {
    logic [31:0] pc;
    bit          pt;
    logic [31:0] ptgt;
  } rec_t;

  int          mBht [4096];
  rec_t        pipe [$];
  bit          mWrReq;
  logic [31:0] mWrPc, mWrTgt, mBrCnt, mMpCnt;

  bit          mPredTaken, mExValid, mWrong, mNeedWrite;
  logic [31:0] mPredPc, mRedirect;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    foreach (mBht[i]) mBht[i] = 1;
    pipe.delete();
    mWrReq = 0; mWrPc = 0; mWrTgt = 0; mBrCnt = 0; mMpCnt = 0;
  endtask

  task automatic computeModel();
    int idx;
    rec_t e;
    idx = int'((if_pc >> 2) & 32'hFFF);
    mPredTaken = btb_hit && (mBht[idx] >= 2);
    mPredPc    = mPredTaken ? btb_target : if_pc + 32'd4;
    mExValid   = (pipe.size() == 2) && !stall;
    mWrong = 0; mNeedWrite = 0; mRedirect = 0;
    if (mExValid) begin
      e = pipe[1];
      if (ex_is_branch) begin
        mWrong     = (ex_taken != e.pt) || (ex_taken && e.pt && ex_target != e.ptgt);
        mNeedWrite = ex_taken && (!e.pt || ex_target != e.ptgt);
        mRedirect  = ex_taken ? ex_target : e.pc + 32'd4;
      end else if (e.pt) begin
        mWrong    = 1;
        mRedirect = e.pc + 32'd4;
      end
    end
  endtask

  task automatic checkOutput();
    computeModel();
    checkVal("pred_taken", {31'd0, pred_taken}, {31'd0, mPredTaken});
    checkVal("pred_pc", pred_pc, mPredPc);
    checkVal("mispredict", {31'd0, mispredict}, {31'd0, mWrong});
    if (mWrong) checkVal("redirect_pc", redirect_pc, mRedirect);
    checkVal("btb_wr_req", {31'd0, btb_wr_req}, {31'd0, mWrReq});
    if (mWrReq) begin
      checkVal("btb_wr_pc", btb_wr_pc, mWrPc);
      checkVal("btb_wr_target", btb_wr_target, mWrTgt);
    end
    checkVal("branch_cnt", branch_cnt, mBrCnt);
    checkVal("mispredict_cnt", mispredict_cnt, mMpCnt);
  endtask

  // Drive one cycle's inputs just after the edge and check at the negedge.
  task automatic applyStimulus(input bit r, input logic [31:0] pc, input bit hit,
                               input logic [31:0] tgt, input bit st, input bit isb,
                               input bit tk, input logic [31:0] extgt, input bit doCheck = 1);
    rst = r; if_pc = pc; btb_hit = hit; btb_target = tgt;
    stall = st; ex_is_branch = isb; ex_taken = tk; ex_target = extgt;
    @(negedge clk);
    if (doCheck) checkOutput();
    else computeModel();
  endtask

  // Apply the architectural effect of the current cycle to the model, then step.
  task automatic advance();
    int ei;
    rec_t n;
    if (rst) begin
      modelReset();
    end else begin
      if (mExValid && ex_is_branch) begin
        ei = int'((pipe[1].pc >> 2) & 32'hFFF);
        if (ex_taken) mBht[ei] = (mBht[ei] == 3) ? 3 : mBht[ei] + 1;
        else          mBht[ei] = (mBht[ei] == 0) ? 0 : mBht[ei] - 1;
        mBrCnt = mBrCnt + 1;
        if (mWrong) mMpCnt = mMpCnt + 1;
      end
      mWrReq = mNeedWrite;
      if (mNeedWrite) begin
        mWrPc  = pipe[1].pc;
        mWrTgt = ex_target;
      end
      if (!stall) begin
        if (mWrong) pipe.delete();
        else begin
          n.pc = if_pc; n.pt = mPredTaken; n.ptgt = btb_target;
          pipe.push_front(n);
          if (pipe.size() > 2) void'(pipe.pop_back());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Fetch a predicted branch and a filler so the branch sits in ID/EX.
  task automatic fetchBranch(input logic [31:0] pc, input logic [31:0] tgt);
    applyStimulus(0, pc, 1, tgt, 0, 0, 0, 32'h0);
    advance();
    applyStimulus(0, 32'h800, 0, 32'h0, 0, 0, 0, 32'h0);
    advance();
  endtask

  task automatic resolve(input bit tk, input logic [31:0] tgt, input bit expMp,
                         input logic [31:0] expRedirect);
    applyStimulus(0, 32'h804, 0, 32'h0, 0, 1, tk, tgt);
    checkVal("resolve mispredict", {31'd0, mispredict}, {31'd0, expMp});
    if (expMp) checkVal("resolve redirect_pc", redirect_pc, expRedirect);
    advance();
  endtask

  logic [31:0] pcs [6] = '{32'h40, 32'h100, 32'h200, 32'h300, 32'h4100, 32'hFFFF_FFFC};
  bit          nt1 [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    modelReset();
    applyStimulus(1, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    advance();
    applyStimulus(1, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    advance();

    // Reset state and first prediction with a weakly-not-taken counter.
    applyStimulus(0, 32'h100, 1, 32'h200, 0, 0, 0, 32'h0);
    checkVal("reset pred_taken", {31'd0, pred_taken}, 32'd0);
    checkVal("reset pred_pc", pred_pc, 32'h104);
    checkVal("reset branch_cnt", branch_cnt, 32'd0);
    checkVal("reset btb_wr_req", {31'd0, btb_wr_req}, 32'd0);
    advance();
    applyStimulus(0, 32'h800, 0, 32'h0, 0, 0, 0, 32'h0);
    advance();
    resolve(1, 32'h200, 1, 32'h200);
    applyStimulus(0, 32'h200, 0, 32'h0, 0, 0, 0, 32'h0);
    checkVal("wr pulse req", {31'd0, btb_wr_req}, 32'd1);
    checkVal("wr pulse pc", btb_wr_pc, 32'h100);
    checkVal("wr pulse target", btb_wr_target, 32'h200);
    advance();
    applyStimulus(0, 32'h204, 0, 32'h0, 0, 0, 0, 32'h0);
    checkVal("wr pulse ends", {31'd0, btb_wr_req}, 32'd0);
    advance();

    // Second taken resolution is predicted correctly and saturates to ST.
    fetchBranch(32'h100, 32'h200);
    resolve(1, 32'h200, 0, 32'h0);
    applyStimulus(0, 32'h100, 1, 32'h200, 0, 0, 0, 32'h0);
    checkVal("ST pred_pc", pred_pc, 32'h200);
    advance();
    applyStimulus(0, 32'h800, 0, 32'h0, 0, 0, 0, 32'h0);
    advance();

    // Not-taken walk down from ST: mispredicts only while predicted taken.
    resolve(0, 32'h0, 1, 32'h104);
    for (int k = 0; k < 3; k++) begin
      fetchBranch(32'h100, 32'h200);
      resolve(0, 32'h0, nt1[k], 32'h104);
    end

    // Train back up, then a predicted-taken branch resolves to another target.
    fetchBranch(32'h100, 32'h200);
    resolve(1, 32'h200, 1, 32'h200);
    applyStimulus(0, 32'h808, 0, 32'h0, 0, 0, 0, 32'h0);
    advance();
    fetchBranch(32'h100, 32'h200);
    resolve(1, 32'h200, 1, 32'h200);
    applyStimulus(0, 32'h808, 0, 32'h0, 0, 0, 0, 32'h0);
    advance();
    fetchBranch(32'h100, 32'h200);
    resolve(1, 32'h300, 1, 32'h300);
    applyStimulus(0, 32'h808, 0, 32'h0, 0, 0, 0, 32'h0);
    checkVal("retarget wr target", btb_wr_target, 32'h300);
    checkVal("retarget wr req", {31'd0, btb_wr_req}, 32'd1);
    advance();

    // Mispredict held off by stall, then resolved once and flushed.
    fetchBranch(32'h100, 32'h200);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 32'h900, 1, 32'h200, 1, 1, 0, 32'h0);
      checkVal("stalled mispredict", {31'd0, mispredict}, 32'd0);
      advance();
    end
    resolve(0, 32'h0, 1, 32'h104);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 32'h808, 0, 32'h0, 0, 1, 1, 32'h999);
      checkVal("post-flush mispredict", {31'd0, mispredict}, 32'd0);
      advance();
    end

    // Non-branch alias at 0x40 redirects to fall-through without a BTB write.
    fetchBranch(32'h40, 32'h500);
    resolve(1, 32'h500, 1, 32'h500);
    fetchBranch(32'h40, 32'h500);
    resolve(1, 32'h500, 0, 32'h0);
    fetchBranch(32'h40, 32'h500);
    applyStimulus(0, 32'h804, 0, 32'h0, 0, 0, 0, 32'h0);
    checkVal("alias mispredict", {31'd0, mispredict}, 32'd1);
    checkVal("alias redirect_pc", redirect_pc, 32'h44);
    advance();
    applyStimulus(0, 32'h808, 0, 32'h0, 0, 0, 0, 32'h0);
    checkVal("alias no btb write", {31'd0, btb_wr_req}, 32'd0);
    advance();

    // Reset with a branch in flight.
    fetchBranch(32'h100, 32'h200);
    applyStimulus(1, 32'h0, 0, 32'h0, 0, 1, 1, 32'h300);
    advance();
    applyStimulus(0, 32'h40, 1, 32'h500, 0, 1, 1, 32'h300);
    checkVal("midreset branch_cnt", branch_cnt, 32'd0);
    checkVal("midreset mispredict_cnt", mispredict_cnt, 32'd0);
    checkVal("midreset btb_wr_req", {31'd0, btb_wr_req}, 32'd0);
    checkVal("midreset pred_taken", {31'd0, pred_taken}, 32'd0);
    checkVal("midreset mispredict", {31'd0, mispredict}, 32'd0);
    advance();

    // Randomized traffic over a small, aliasing PC set including the wrap PC.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    pcs[$urandom_range(0, 5)],
                    $urandom_range(0, 3) != 0,
                    pcs[$urandom_range(0, 5)],
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) < 7,
                    $urandom_range(0, 1) == 1,
                    pcs[$urandom_range(0, 5)]);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Direction predictor and resolution stage paired with the direct-mapped branch target buffer.
- IF side: qualifies the BTB hit with a 2-bit bimodal history table (BHT) and produces the fetch prediction.
- Carries prediction metadata through the IF/ID and ID/EX stages.
- EX side: compares the prediction with the resolved outcome, then raises mispredict/redirect, updates the BHT and issues BTB write requests.

Parameters:
- BHT_ADDR_LEN, 12, index width of the BHT. Index is pc[BHT_ADDR_LEN+1:2]; the table has 2^BHT_ADDR_LEN 2-bit counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_pc  in  32  current fetch PC
- btb_hit  in  1  BTB tag hit for if_pc
- btb_target  in  32  BTB predicted target for if_pc
- pred_taken  out  1  fetch predicted taken
- pred_pc  out  32  next fetch PC
- stall  in  1  pipeline hold; freezes the metadata registers and suppresses resolution
- ex_is_branch  in  1  EX instruction is a branch/jump
- ex_taken  in  1  resolved direction
- ex_target  in  32  resolved target
- mispredict  out  1  flush IF/ID and ID/EX, redirect fetch
- redirect_pc  out  32  correct next PC
- btb_wr_req  out  1  BTB write request
- btb_wr_pc  out  32  branch PC to write
- btb_wr_target  out  32  target to write
- branch_cnt  out  32  resolved branches
- mispredict_cnt  out  32  mispredictions

Behaviour:
- Reset:
  - Clock is clk; reset is synchronous and active-high on rst.
  - All BHT counters reset to 2'b01 (weakly not-taken).
  - Metadata valid bits, btb_wr_req, btb_wr_pc, btb_wr_target, branch_cnt and mispredict_cnt all reset to 0.
  - Reset asserted mid-operation discards in-flight metadata and any pending BTB write.
- Prediction (combinational):
  - pred_taken = btb_hit & BHT[if_idx][1].
  - pred_pc = pred_taken ? btb_target : if_pc+4 (mod 2^32).
- Metadata pipeline:
  - Two registers, IF/ID and ID/EX, each holding {valid, pc, pred_taken, pred_target}.
  - stall=1: both hold their contents.
  - No stall: IF/ID loads {1, if_pc, pred_taken, btb_target}, and ID/EX loads IF/ID.
  - Resolving mispredict (stall=0): both valid bits clear on the next edge. Flush takes priority over the load.
- Resolution (ex_v = ID/EX.valid & ~stall):
  - Branch case (ex_v & ex_is_branch): mispredict = (ex_taken != pred_taken) | (ex_taken & pred_taken & ex_target != pred_target).
  - Non-branch case (ex_v & ~ex_is_branch & pred_taken, stale BTB alias): mispredict = 1 and redirect_pc = pc+4.
  - redirect_pc = ex_taken ? ex_target : pc+4. It is only meaningful while mispredict=1.
  - mispredict is forced to 0 when stall=1 or ID/EX is invalid.
- Updates (at the edge, only when ex_v & ex_is_branch):
  - BHT[ex_idx] saturates: increment if taken (stop at 3), decrement if not taken (stop at 0).
  - branch_cnt += 1; mispredict_cnt += 1 if mispredict. Both counters wrap at 2^32.
- BTB write path:
  - Condition: ex_taken & (~pred_taken | target mismatch).
  - Registered, 1-cycle latency: btb_wr_req pulses for exactly one cycle with btb_wr_pc = EX pc and btb_wr_target = ex_target. Otherwise btb_wr_req=0.
  - The alias mispredict does not write the BTB and does not touch the BHT.
- Same-cycle BHT read/write to one index: IF sees the old counter (no bypass).
- Redirect cycle: IF prediction outputs are still produced; the owner of the PC mux gives mispredict priority over pred_pc.

Decomposition:
- Shared package: localparam for the 2-bit counter encodings (SNT=0, WNT=1, WT=2, ST=3, reset WNT); a bp_meta_t struct {valid, pc, pred_taken, pred_target}.
- Sub-module bimodal_bht: 2-bit counter array with one combinational read port, one synchronous saturating-update port, and synchronous reset.

Test Plan:
- Reset, then if_pc=0x100, btb_hit=1 -> pred_taken=0 and pred_pc=0x104 (counter WNT).
- Branch at 0x100 resolves taken to 0x200 twice, stall=0 -> mispredict=1 with redirect_pc=0x200 the first time; btb_wr_req pulses one cycle later with pc 0x100 / target 0x200; counter reaches ST; next fetch of 0x100 with btb_hit=1 predicts 0x200.
- Counter at ST, three not-taken resolutions -> counter sequence 2,1,0 and stays at 0 on a fourth; each resolution mispredicts only while pred_taken=1.
- Predicted taken to 0x200, resolved taken to 0x300 -> mispredict=1, redirect_pc=0x300, BTB write target 0x300.
- Mispredict with stall=1 held for 3 cycles -> mispredict=0, no BHT/counter change; when stall drops, one resolution, branch_cnt increments exactly once, and IF/ID and ID/EX are invalid next cycle.
- Non-branch in EX with pred_taken=1 at pc 0x40 -> mispredict=1, redirect_pc=0x44, btb_wr_req stays 0; rst asserted mid-stream -> all counters 0, valids 0, BHT back to WNT.
